uart_tx_8n1: RTL and testbench
==============================

Name: uart_tx_8n1

Overview:
- Byte-serial UART transmitter that consumes the tx_data / ld_tx_data / tx_enable / tx_empty interface driven by the image sender.
- Serialises each byte as an 8N1 frame (or 8N2) on the FPGA TX pin.
- Has a one-byte holding register in front of the shift register, so the sender can queue the next byte while the current frame is on the wire.
- Single clock domain; clk is the system clock, and bit timing comes from an internal baud counter.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200). Legal range 2..65535.
- STOP_BITS, 1, number of stop bits. Legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- tx_data  input  8  byte to transmit; sampled only on an accepted load.
- ld_tx_data  input  1  load strobe; accepted when tx_empty=1.
- tx_enable  input  1  permits a new frame to start; does not abort a frame in progress.
- tx_empty  output  1  holding register empty; a load is accepted this cycle.
- tx_busy  output  1  a frame is on the wire (state != IDLE).
- tx_overrun  output  1  one-cycle pulse when ld_tx_data is asserted while tx_empty=0.
- tx_out  output  1  serial line; idles high.

Behaviour:
- Reset (rst_n=0 at a clk edge): tx_out=1, tx_empty=1, tx_busy=0, tx_overrun=0.
  - State=IDLE; baud counter=0; bit index=0; holding and shift registers cleared.
  - Reset mid-frame aborts immediately; the line is high on the next cycle.
- Holding register:
  - ld_tx_data=1 with tx_empty=1: capture tx_data; tx_empty=0 from the next cycle.
  - ld_tx_data=1 with tx_empty=0: data dropped, holding register unchanged, tx_overrun=1 next cycle for exactly one cycle.
- Transfer: in IDLE, or at the final cycle of the last stop bit, if holding is full and tx_enable=1:
  - copy holding into the shift register;
  - tx_empty=1 next cycle;
  - enter START.
- A load in the same cycle as a transfer sees tx_empty=0, so it is an overrun. The sender must wait for tx_empty.
- Latency: ld_tx_data accepted at cycle N, from IDLE with tx_enable=1:
  - holding full at N+1;
  - transfer at N+1;
  - tx_out low (start bit) from N+2.
- State machine:
  - IDLE: tx_out=1, tx_busy=0; exits to START on transfer.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_out=shift[bit index], LSB first. Each bit lasts CLKS_PER_BIT cycles; after bit 7, go to STOP.
  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - At the last cycle, if a transfer condition holds, go straight to START (no idle gap).
    - Otherwise go to IDLE.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0.
  - Is held at 0 in IDLE and restarts at 0 on every state entry.
  - Width = clog2(CLKS_PER_BIT).
  - Bit index is 3 bits, 0..7. A stop-bit counter is used when STOP_BITS=2.
- Frame length: exactly (9+STOP_BITS)*CLKS_PER_BIT cycles.
- tx_enable:
  - Deasserting it mid-frame has no effect on that frame.
  - While it is 0, a full holding register waits; tx_empty stays 0 and tx_out stays high.
- tx_data changes after acceptance have no effect on the byte being sent.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams IDLE/START/DATA/STOP (2 bits);
  - default CLKS_PER_BIT=434;
  - DATA_BITS=8.
- Sub-module uart_baud_gen:
  - parameterised counter with clear input and a bit_done pulse at count CLKS_PER_BIT-1;
  - reused by the planned uart_rx.

Test Plan (bench uses CLKS_PER_BIT=4, STOP_BITS=1 unless stated):
- Reset: hold rst_n=0 for 3 cycles mid-frame -> next cycle tx_out=1, tx_empty=1, tx_busy=0, tx_overrun=0.
- Single byte 0xA5, tx_enable=1, ld at cycle N:
  - tx_out low for cycles N+2..N+5;
  - then bits 1,0,1,0,0,1,0,1, each 4 cycles;
  - stop high 4 cycles; tx_busy falls at N+42.
- Back-to-back: load 0x55, then load 0x0F on the first cycle tx_empty=1 again -> two frames with no idle cycle between the stop bit and the second start bit; total 80 cycles of tx_busy=1.
- Overrun: load 0x11, then assert ld_tx_data with 0x22 while tx_empty=0 -> tx_overrun=1 for one cycle; only 0x11 is serialised (and 0x22 never appears).
- tx_enable gating:
  - load 0x3C with tx_enable=0 -> tx_out stays 1 and tx_empty=0 for 20 cycles;
  - raise tx_enable -> start bit begins 1 cycle later.
  - Dropping tx_enable mid-frame still completes that frame.
- STOP_BITS=2, CLKS_PER_BIT=3, byte 0xFF -> frame 33 cycles: start low 3, data high 24, stop high 6.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame constants,
// used by the transmitter now and by the planned receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 434;
  localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_tx_8n1_if.sv
// Byte handshake between the image sender (master) and the UART transmitter (slave).
interface uart_tx_8n1_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 ld_tx_data;
  logic                 tx_enable;
  logic                 tx_empty;
  logic                 tx_busy;
  logic                 tx_overrun;

  modport master (
    output tx_data, ld_tx_data, tx_enable,
    input  tx_empty, tx_busy, tx_overrun
  );

  modport slave (
    input  tx_data, ld_tx_data, tx_enable,
    output tx_empty, tx_busy, tx_overrun
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and wraps, flagging the last cycle of each bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  assign bit_done = (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (bit_done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1/8N2 UART transmitter with a one-byte holding register ahead of the shift register,
// so the next byte can be queued while the current frame is on the wire.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_tx_8n1_if.slave  bus,
  output logic          tx_out
);

  uart_state_t          state, state_next;
  logic [DATA_BITS-1:0] hold_reg, hold_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 hold_empty, hold_empty_next;
  logic [2:0]           bit_idx, bit_idx_next;
  logic                 stop_cnt, stop_cnt_next;
  logic                 tx_out_next;
  logic                 busy_q, overrun_q;
  logic                 bit_done, last_stop, load_ok, xfer;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == IDLE),
    .bit_done (bit_done)
  );

  assign load_ok   = bus.ld_tx_data && hold_empty;
  assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));
  // A transfer may start from IDLE or on the final cycle of the last stop bit (no idle gap).
  assign xfer      = !hold_empty && bus.tx_enable &&
                     ((state == IDLE) || ((state == STOP) && bit_done && last_stop));

  always_comb begin
    state_next      = state;
    hold_next       = hold_reg;
    shift_next      = shift_reg;
    hold_empty_next = hold_empty;
    bit_idx_next    = bit_idx;
    stop_cnt_next   = stop_cnt;
    tx_out_next     = 1'b1;

    if (load_ok) begin
      hold_next       = bus.tx_data;
      hold_empty_next = 1'b0;
    end
    if (xfer) begin
      shift_next      = hold_reg;
      hold_empty_next = 1'b1;
    end

    case (state)
      IDLE:  if (xfer) state_next = START;
      START: if (bit_done) state_next = DATA;
      DATA: begin
        if (bit_done) begin
          if (bit_idx == 3'(DATA_BITS - 1)) begin
            state_next   = STOP;
            bit_idx_next = '0;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (last_stop) begin
            stop_cnt_next = 1'b0;
            state_next    = xfer ? START : IDLE;
          end else begin
            stop_cnt_next = stop_cnt + 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The line is driven from next-state values so tx_out is a plain register.
    case (state_next)
      START:   tx_out_next = 1'b0;
      DATA:    tx_out_next = shift_next[bit_idx_next];
      default: tx_out_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_reg   <= '0;
      shift_reg  <= '0;
      hold_empty <= 1'b1;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      tx_out     <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state      <= state_next;
      hold_reg   <= hold_next;
      shift_reg  <= shift_next;
      hold_empty <= hold_empty_next;
      bit_idx    <= bit_idx_next;
      stop_cnt   <= stop_cnt_next;
      tx_out     <= tx_out_next;
      busy_q     <= (state_next != IDLE);
      overrun_q  <= bus.ld_tx_data && !hold_empty;
    end
  end

  assign bus.tx_empty   = hold_empty;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1: one 8N1 instance at 4 clk/bit and one 8N2 instance at 3 clk/bit.
module tb_uart_tx_8n1;
  import uart_pkg::*;

  logic clk;
  logic rst_n;
  logic tx_out;
  logic tx_out2;
  int   cyc;
  int   total_checks;
  int   pass_checks;
  int   fail_checks;

  uart_tx_8n1_if bus ();
  uart_tx_8n1_if bus2 ();

  uart_tx_8n1 #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .tx_out (tx_out)
  );

  uart_tx_8n1 #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus2),
    .tx_out (tx_out2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_checks++;
    assert (obs === exp) pass_checks = pass_checks + 1;
    else begin
      fail_checks++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int which, input logic ld, input logic [7:0] data, input logic en);
    if (which == 0) begin
      bus.ld_tx_data = ld;
      bus.tx_data    = data;
      bus.tx_enable  = en;
    end else begin
      bus2.ld_tx_data = ld;
      bus2.tx_data    = data;
      bus2.tx_enable  = en;
    end
  endtask

  function automatic logic [127:0] frame_bits(input logic [7:0] b, input int cpb, input int stops);
    logic [127:0] f;
    logic [6:0]   p;
    f = '0;
    p = '0;
    for (int i = 0; i < cpb; i++) begin f[p] = 1'b0; p++; end
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < cpb; i++) begin f[p] = b[k]; p++; end
    for (int i = 0; i < stops * cpb; i++) begin f[p] = 1'b1; p++; end
    return f;
  endfunction

  // Records tx_out over the busy window. mode 1: queue extra on the first empty cycle while busy;
  // mode 2: load extra on the very next cycle (overrun); mode 3: drop tx_enable mid-frame.
  task automatic apply_stimulus(input int which, input int mode, input logic [7:0] extra,
                                output logic [127:0] bits, output int nbusy,
                                output int first_busy, output int fall_cyc,
                                output int ovr_pulses, output int ovr_cyc);
    logic busy_s, out_s, empty_s, ovr_s, en, ld;
    logic [7:0] data;
    bit   done2;
    bits = '0; nbusy = 0; first_busy = -1; fall_cyc = -1;
    ovr_pulses = 0; ovr_cyc = -1; done2 = 0;
    en = (which == 0) ? bus.tx_enable : bus2.tx_enable;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (which == 0) begin
        busy_s = bus.tx_busy; out_s = tx_out; empty_s = bus.tx_empty; ovr_s = bus.tx_overrun;
      end else begin
        busy_s = bus2.tx_busy; out_s = tx_out2; empty_s = bus2.tx_empty; ovr_s = bus2.tx_overrun;
      end
      if (ovr_s) begin ovr_pulses++; ovr_cyc = cyc; end
      if (busy_s) begin
        if (nbusy == 0) first_busy = cyc;
        if (nbusy < 128) bits[nbusy[6:0]] = out_s;
        nbusy++;
      end else if (nbusy > 0) begin
        fall_cyc = cyc;
        break;
      end
      ld   = 1'b0;
      data = 8'hC3;
      if (mode == 1 && !done2 && empty_s && nbusy > 0) begin ld = 1'b1; data = extra; done2 = 1; end
      if (mode == 2 && !done2) begin ld = 1'b1; data = extra; done2 = 1; end
      if (mode == 3 && nbusy == 10) en = 1'b0;
      drive(which, ld, data, en);
    end
  endtask

  logic [127:0] bits;
  int nb, fb, fc, op, oc, n, m, bad_out, bad_empty, bad_busy;

  initial begin
    cyc = 0; total_checks = 0; pass_checks = 0; fail_checks = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check_output("reset_tx_out", 128'(tx_out), 128'(1'b1));
    check_output("reset_empty", 128'(bus.tx_empty), 128'(1'b1));
    check_output("reset_busy", 128'(bus.tx_busy), 128'(1'b0));
    check_output("reset_overrun", 128'(bus.tx_overrun), 128'(1'b0));

    $display("[TB] single byte 0xA5");
    n = cyc;
    drive(0, 1'b1, 8'hA5, 1'b1);
    apply_stimulus(0, 0, 8'h00, bits, nb, fb, fc, op, oc);
    check_output("a5_first_busy", 128'(fb), 128'(n + 2));
    check_output("a5_busy_fall", 128'(fc), 128'(n + 42));
    check_output("a5_busy_len", 128'(nb), 128'(40));
    check_output("a5_line", bits, 128'(40'hFF0F00F0F0));
    check_output("a5_no_overrun", 128'(op), 128'(0));
    check_output("a5_idle_line", 128'(tx_out), 128'(1'b1));
    check_output("a5_idle_empty", 128'(bus.tx_empty), 128'(1'b1));

    $display("[TB] back-to-back 0x55 then 0x0F");
    tick();
    n = cyc;
    drive(0, 1'b1, 8'h55, 1'b1);
    apply_stimulus(0, 1, 8'h0F, bits, nb, fb, fc, op, oc);
    check_output("b2b_first_busy", 128'(fb), 128'(n + 2));
    check_output("b2b_busy_len", 128'(nb), 128'(80));
    check_output("b2b_line", bits, frame_bits(8'h55, 4, 1) | (frame_bits(8'h0F, 4, 1) << 40));
    check_output("b2b_no_overrun", 128'(op), 128'(0));

    $display("[TB] overrun 0x11 then 0x22");
    tick();
    n = cyc;
    drive(0, 1'b1, 8'h11, 1'b1);
    apply_stimulus(0, 2, 8'h22, bits, nb, fb, fc, op, oc);
    check_output("ovr_pulses", 128'(op), 128'(1));
    check_output("ovr_cycle", 128'(oc), 128'(n + 2));
    check_output("ovr_busy_len", 128'(nb), 128'(40));
    check_output("ovr_line", bits, frame_bits(8'h11, 4, 1));
    repeat (3) tick();
    check_output("ovr_no_second_frame", 128'(bus.tx_busy), 128'(1'b0));
    check_output("ovr_hold_empty", 128'(bus.tx_empty), 128'(1'b1));

    $display("[TB] tx_enable gating 0x3C");
    drive(0, 1'b1, 8'h3C, 1'b0);
    tick();
    drive(0, 1'b0, 8'h00, 1'b0);
    bad_out = 0; bad_empty = 0; bad_busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_out !== 1'b1) bad_out++;
      if (bus.tx_empty !== 1'b0) bad_empty++;
      if (bus.tx_busy !== 1'b0) bad_busy++;
    end
    check_output("gate_line_high", 128'(bad_out), 128'(0));
    check_output("gate_held_full", 128'(bad_empty), 128'(0));
    check_output("gate_not_busy", 128'(bad_busy), 128'(0));
    m = cyc;
    drive(0, 1'b0, 8'h00, 1'b1);
    apply_stimulus(0, 3, 8'h00, bits, nb, fb, fc, op, oc);
    check_output("gate_start_latency", 128'(fb), 128'(m + 1));
    check_output("gate_busy_len", 128'(nb), 128'(40));
    check_output("gate_line", bits, frame_bits(8'h3C, 4, 1));

    $display("[TB] reset mid-frame");
    drive(0, 1'b1, 8'h00, 1'b1);
    tick();
    drive(0, 1'b0, 8'h00, 1'b1);
    repeat (8) tick();
    check_output("pre_reset_line_low", 128'(tx_out), 128'(1'b0));
    rst_n = 1'b0;
    tick();
    check_output("reset_line_next", 128'(tx_out), 128'(1'b1));
    repeat (2) tick();
    check_output("mid_reset_tx_out", 128'(tx_out), 128'(1'b1));
    check_output("mid_reset_empty", 128'(bus.tx_empty), 128'(1'b1));
    check_output("mid_reset_busy", 128'(bus.tx_busy), 128'(1'b0));
    check_output("mid_reset_overrun", 128'(bus.tx_overrun), 128'(1'b0));
    rst_n = 1'b1;
    repeat (3) tick();
    check_output("post_reset_busy", 128'(bus.tx_busy), 128'(1'b0));
    check_output("post_reset_line", 128'(tx_out), 128'(1'b1));

    $display("[TB] two stop bits, 3 clk/bit, 0xFF");
    n = cyc;
    drive(1, 1'b1, 8'hFF, 1'b1);
    apply_stimulus(1, 0, 8'h00, bits, nb, fb, fc, op, oc);
    check_output("s2_first_busy", 128'(fb), 128'(n + 2));
    check_output("s2_busy_len", 128'(nb), 128'(33));
    check_output("s2_line", bits, 128'(33'h1FFFFFFF8));

    $display("%0d/%0d checks passed", pass_checks, total_checks);
    $finish;
  end

endmodule
